// File: rtl/toy_bus_ddec_node_buf_pkg.sv
// Shared toy bus types: beat payload struct and default route table.
// Imported by the decoder node and its per-channel skid buffers.
package toy_bus_ddec_node_buf_pkg;

    localparam int TOY_BUS_DATA_W  = 256;
    localparam int TOY_BUS_SB_W    = 10;
    localparam int TOY_BUS_ID_W    = 4;
    localparam int TOY_BUS_MAX_OUT = 16;
    localparam int TOY_BUS_TBL_W   = 256;

    typedef struct packed {
        logic                      opcode;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic [TOY_BUS_SB_W-1:0]   sideband;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_pld_t;

    // Channel i serves tgt_id i.
    function automatic logic [TOY_BUS_TBL_W-1:0] toy_bus_route_dflt(
        input int n,
        input int w
    );
        logic [TOY_BUS_TBL_W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = r | (TOY_BUS_TBL_W'(i) << (i * w));
        end
        return r;
    endfunction

    localparam logic [TOY_BUS_MAX_OUT*TOY_BUS_ID_W-1:0] TOY_BUS_ROUTE_DFLT =
        (TOY_BUS_MAX_OUT*TOY_BUS_ID_W)'(
            toy_bus_route_dflt(TOY_BUS_MAX_OUT, TOY_BUS_ID_W));

endpackage

// File: rtl/toy_bus_ddec_node_buf_skid2.sv
// Two-entry valid/ready FIFO; head entry drives the outputs from flops.
// in_rdy depends only on occupancy, never on out_rdy.
module toy_bus_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_pld,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_pld
);

    logic [1:0]   cnt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_rdy  = (cnt != 2'd2);
    assign out_vld = (cnt != 2'd0);
    assign out_pld = head;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        head <= in_pld;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head <= in_pld;
                        2'b10: begin
                            tail <= in_pld;
                            cnt  <= 2'd2;
                        end
                        2'b01: cnt <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        cnt  <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/toy_bus_ddec_node_buf.sv
// Toy bus decoder node: steers beats by tgt_id into per-channel skid
// buffers; unrouted beats are consumed and counted.
module toy_bus_ddec_node_buf
    import toy_bus_ddec_node_buf_pkg::*;
#(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 256,
    parameter int SB_W   = 10,
    parameter int ID_W   = 4,
    parameter logic [N_OUT*ID_W-1:0] ROUTE_TBL =
        (N_OUT*ID_W)'(toy_bus_route_dflt(N_OUT, ID_W)),
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic                    in_opcode,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SB_W-1:0]         in_sideband,
    input  logic [ID_W-1:0]         in_src_id,
    input  logic [ID_W-1:0]         in_tgt_id,
    output logic [N_OUT-1:0]        out_vld,
    input  logic [N_OUT-1:0]        out_rdy,
    output logic [N_OUT-1:0]        out_opcode,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT*SB_W-1:0]   out_sideband,
    output logic [N_OUT*ID_W-1:0]   out_src_id,
    output logic [N_OUT*ID_W-1:0]   out_tgt_id,
    input  logic                    drop_clr,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    drop_err
);

    localparam int PLD_W = 1 + DATA_W + SB_W + 2 * ID_W;

    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] ch_rdy;
    logic             miss;
    logic             drop;
    logic [PLD_W-1:0] pld_in;

    assign pld_in = {in_opcode, in_data, in_sideband, in_src_id, in_tgt_id};
    assign miss   = ~|hit;
    assign in_rdy = miss | |(hit & ch_rdy);
    assign drop   = in_vld & miss;

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        logic [PLD_W-1:0] pld_out;

        assign hit[i] = (in_tgt_id == ROUTE_TBL[i*ID_W +: ID_W]);

        toy_bus_skid2 #(
            .W (PLD_W)
        ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (in_vld & hit[i]),
            .in_rdy  (ch_rdy[i]),
            .in_pld  (pld_in),
            .out_vld (out_vld[i]),
            .out_rdy (out_rdy[i]),
            .out_pld (pld_out)
        );

        assign {out_opcode[i],
                out_data[i*DATA_W +: DATA_W],
                out_sideband[i*SB_W +: SB_W],
                out_src_id[i*ID_W +: ID_W],
                out_tgt_id[i*ID_W +: ID_W]} = pld_out;
    end

    // A clear coinciding with a drop leaves exactly that drop recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            drop_err <= 1'b0;
        end else if (drop_clr) begin
            drop_cnt <= drop ? CNT_W'(1) : '0;
            drop_err <= drop;
        end else if (drop) begin
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_bus_ddec_node_buf.sv
// Bench for toy_bus_ddec_node_buf: vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_toy_bus_ddec_node_buf;
    import toy_bus_ddec_node_buf_pkg::*;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SW = 10;
    localparam int IW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_vld;
    logic            in_rdy;
    logic            in_opcode;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sideband;
    logic [IW-1:0]   in_src_id;
    logic [IW-1:0]   in_tgt_id;
    logic [N-1:0]    out_vld;
    logic [N-1:0]    out_rdy;
    logic [N-1:0]    out_opcode;
    logic [N*DW-1:0] out_data;
    logic [N*SW-1:0] out_sideband;
    logic [N*IW-1:0] out_src_id;
    logic [N*IW-1:0] out_tgt_id;
    logic            drop_clr;
    logic [15:0]     drop_cnt;
    logic            drop_err;

    logic            in_rdy2;
    logic [N-1:0]    out_vld2;
    logic [N-1:0]    out_opcode2;
    logic [N*DW-1:0] out_data2;
    logic [N*SW-1:0] out_sideband2;
    logic [N*IW-1:0] out_src_id2;
    logic [N*IW-1:0] out_tgt_id2;
    logic [1:0]      drop_cnt2;
    logic            drop_err2;

    int checks = 0;
    int errors = 0;

    toy_bus_ddec_node_buf #(
        .N_OUT(N), .DATA_W(DW), .SB_W(SW), .ID_W(IW), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_opcode(in_opcode), .in_data(in_data),
        .in_sideband(in_sideband), .in_src_id(in_src_id),
        .in_tgt_id(in_tgt_id), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_opcode(out_opcode), .out_data(out_data),
        .out_sideband(out_sideband), .out_src_id(out_src_id),
        .out_tgt_id(out_tgt_id), .drop_clr(drop_clr),
        .drop_cnt(drop_cnt), .drop_err(drop_err)
    );

    toy_bus_ddec_node_buf #(
        .N_OUT(N), .DATA_W(DW), .SB_W(SW), .ID_W(IW), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy2),
        .in_opcode(in_opcode), .in_data(in_data),
        .in_sideband(in_sideband), .in_src_id(in_src_id),
        .in_tgt_id(in_tgt_id), .out_vld(out_vld2), .out_rdy(out_rdy),
        .out_opcode(out_opcode2), .out_data(out_data2),
        .out_sideband(out_sideband2), .out_src_id(out_src_id2),
        .out_tgt_id(out_tgt_id2), .drop_clr(drop_clr),
        .drop_cnt(drop_cnt2), .drop_err(drop_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] tgt;
        logic       clr;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_vld;
        int         exp_cnt;
        logic       exp_err;
    } vec_t;

    function automatic vec_t mk(int v, int t, int c, int r,
                                int er, int ev, int ec, int ee);
        vec_t m;
        m.vld     = v[0];
        m.tgt     = 4'(t);
        m.clr     = c[0];
        m.rdy     = 4'(r);
        m.exp_rdy = er[0];
        m.exp_vld = 4'(ev);
        m.exp_cnt = ec;
        m.exp_err = ee[0];
        return m;
    endfunction

    task automatic chk(input string nm, input logic [299:0] act,
                       input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic toy_bus_pld_t rnd_pld(input logic [3:0] tgt);
        toy_bus_pld_t p;
        p.opcode = 1'($urandom);
        for (int k = 0; k < DW / 32; k++) p.data[k*32 +: 32] = $urandom;
        p.sideband = SW'($urandom);
        p.src_id   = IW'($urandom);
        p.tgt_id   = tgt;
        return p;
    endfunction

    function automatic toy_bus_pld_t head(input int i);
        return {out_opcode[i], out_data[i*DW +: DW],
                out_sideband[i*SW +: SW], out_src_id[i*IW +: IW],
                out_tgt_id[i*IW +: IW]};
    endfunction

    task automatic drive(input logic v, input toy_bus_pld_t p);
        in_vld      = v;
        in_opcode   = p.opcode;
        in_data     = p.data;
        in_sideband = p.sideband;
        in_src_id   = p.src_id;
        in_tgt_id   = p.tgt_id;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t         tbl[21];
    toy_bus_pld_t b[3];
    toy_bus_pld_t q[N][$];
    int           dcnt;
    int           dcnt2;
    logic         derr;

    initial begin
        rst_n    = 1'b0;
        out_rdy  = '0;
        drop_clr = 1'b0;
        drive(1'b0, '0);
        #12 rst_n = 1'b1;
        #1;
        chk("reset out_vld", out_vld, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset drop_err", drop_err, 0);
        chk("reset in_rdy", in_rdy, 1);
        step();

        tbl[0]  = mk(1, 0, 0, 15, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 15, 1, 1, 0, 0);
        tbl[2]  = mk(1, 2, 0, 15, 1, 2, 0, 0);
        tbl[3]  = mk(1, 3, 0, 15, 1, 4, 0, 0);
        tbl[4]  = mk(0, 0, 0, 15, 1, 8, 0, 0);
        tbl[5]  = mk(0, 0, 0, 15, 1, 0, 0, 0);
        tbl[6]  = mk(1, 2, 0, 11, 1, 0, 0, 0);
        tbl[7]  = mk(1, 2, 0, 11, 1, 4, 0, 0);
        tbl[8]  = mk(1, 2, 0, 11, 0, 4, 0, 0);
        tbl[9]  = mk(1, 1, 0, 11, 1, 4, 0, 0);
        tbl[10] = mk(0, 0, 0, 11, 1, 6, 0, 0);
        tbl[11] = mk(0, 0, 0, 15, 1, 4, 0, 0);
        tbl[12] = mk(0, 0, 0, 15, 1, 4, 0, 0);
        tbl[13] = mk(0, 0, 0, 15, 1, 0, 0, 0);
        tbl[14] = mk(1, 7, 0, 15, 1, 0, 0, 0);
        tbl[15] = mk(1, 7, 0, 15, 1, 0, 1, 1);
        tbl[16] = mk(1, 7, 0, 15, 1, 0, 2, 1);
        tbl[17] = mk(1, 7, 1, 15, 1, 0, 3, 1);
        tbl[18] = mk(0, 0, 0, 15, 1, 0, 1, 1);
        tbl[19] = mk(0, 0, 1, 15, 1, 0, 1, 1);
        tbl[20] = mk(0, 0, 0, 15, 1, 0, 0, 0);

        for (int r = 0; r < 21; r++) begin
            drive(tbl[r].vld, rnd_pld(tbl[r].tgt));
            drop_clr = tbl[r].clr;
            out_rdy  = tbl[r].rdy;
            #1;
            chk($sformatf("tbl%0d in_rdy", r), in_rdy, tbl[r].exp_rdy);
            chk($sformatf("tbl%0d out_vld", r), out_vld, tbl[r].exp_vld);
            chk($sformatf("tbl%0d drop_cnt", r), drop_cnt, tbl[r].exp_cnt);
            chk($sformatf("tbl%0d drop_err", r), drop_err, tbl[r].exp_err);
            step();
        end
        drop_clr = 1'b0;

        // Back-pressure on channel 2: order and refill timing.
        for (int k = 0; k < 3; k++) b[k] = rnd_pld(4'd2);
        out_rdy = 4'b1011;
        drive(1'b1, b[0]);
        #1 chk("bp beat0 in_rdy", in_rdy, 1);
        step();
        drive(1'b1, b[1]);
        #1 chk("bp beat1 in_rdy", in_rdy, 1);
        step();
        drive(1'b1, b[2]);
        #1 chk("bp beat2 in_rdy", in_rdy, 0);
        chk("bp head0 held", head(2), b[0]);
        step();
        out_rdy = 4'b1111;
        #1 chk("bp release in_rdy", in_rdy, 0);
        chk("bp head0", head(2), b[0]);
        step();
        chk("bp refill in_rdy", in_rdy, 1);
        chk("bp head1", head(2), b[1]);
        step();
        drive(1'b0, '0);
        #1 chk("bp head2", head(2), b[2]);
        chk("bp vld2", out_vld, 4'b0100);
        step();
        chk("bp drained", out_vld, 0);

        // Narrow counter saturation.
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rnd_pld(4'd7));
            step();
        end
        drive(1'b0, '0);
        #1 chk("sat drop_cnt2", drop_cnt2, 3);
        chk("sat drop_err2", drop_err2, 1);
        chk("sat drop_cnt", drop_cnt, 5);
        chk("sat no out_vld", out_vld, 0);

        // Asynchronous reset with two beats buffered in channel 0.
        out_rdy = 4'b0000;
        drive(1'b1, rnd_pld(4'd0));
        step();
        drive(1'b1, rnd_pld(4'd0));
        step();
        drive(1'b0, '0);
        #1 chk("rst pre in_rdy", in_rdy, 0);
        chk("rst pre out_vld", out_vld, 4'b0001);
        rst_n = 1'b0;
        #1 chk("rst async out_vld", out_vld, 0);
        chk("rst async drop_err", drop_err, 0);
        chk("rst async drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        #1 chk("rst post in_rdy", in_rdy, 1);
        step();
        chk("rst post out_vld", out_vld, 0);

        // Randomized traffic against a queue model.
        dcnt  = 0;
        dcnt2 = 0;
        derr  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic         v;
            logic         clr;
            logic [3:0]   tgt;
            logic [3:0]   rdy;
            logic         erdy;
            logic         drp;
            toy_bus_pld_t p;
            v   = ($urandom_range(0, 3) != 0);
            tgt = 4'($urandom_range(0, 7));
            rdy = 4'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            p   = rnd_pld(tgt);
            drive(v, p);
            out_rdy  = rdy;
            drop_clr = clr;
            #1;
            erdy = (tgt >= 4) || (q[tgt].size() < 2);
            chk("rnd in_rdy", in_rdy, erdy);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rnd out_vld%0d", i), out_vld[i],
                    q[i].size() != 0);
                if (q[i].size() != 0 && out_vld[i])
                    chk($sformatf("rnd head%0d", i), head(i), q[i][0]);
            end
            chk("rnd drop_cnt", drop_cnt, dcnt);
            chk("rnd drop_err", drop_err, derr);
            chk("rnd drop_cnt2", drop_cnt2, dcnt2);
            for (int i = 0; i < N; i++)
                if (q[i].size() != 0 && rdy[i]) void'(q[i].pop_front());
            if (v && erdy && tgt < 4) q[tgt].push_back(p);
            drp = v && (tgt >= 4);
            if (clr) begin
                dcnt  = drp ? 1 : 0;
                dcnt2 = drp ? 1 : 0;
                derr  = drp;
            end else if (drp) begin
                dcnt  = (dcnt < 65535) ? dcnt + 1 : dcnt;
                dcnt2 = (dcnt2 < 3) ? dcnt2 + 1 : dcnt2;
                derr  = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
